// File: rtl/alu_uart_ctrl.sv
// Frame controller between a UART and an ALU: collects operand A, operand B and opcode
// bytes, captures the ALU result and requests its transmission, with inter-byte timeout.
module alu_uart_ctrl #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6,
   parameter int TIMEOUT = 1000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_done_tick,
   input  logic [NB_DATA-1:0] rx_data,
   input  logic [NB_DATA-1:0] alu_result,
   input  logic               tx_done_tick,
   output logic [NB_DATA-1:0] alu_a,
   output logic [NB_DATA-1:0] alu_b,
   output logic [NB_OP-1:0]   alu_op,
   output logic               tx_start,
   output logic [NB_DATA-1:0] tx_data,
   output logic               frame_err,
   output logic               overrun,
   output logic [2:0]         fsm_state
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      CALC    = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          load_a, load_b, load_op, load_tx;
   logic          expire, rx_over;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_op    = 1'b0;
      load_tx    = 1'b0;
      expire     = 1'b0;
      rx_over    = 1'b0;
      case (state)
         WAIT_A: begin
            if (rx_done_tick) begin
               load_a     = 1'b1;
               cnt_next   = '0;
               state_next = WAIT_B;
            end
         end
         WAIT_B: begin
            // A byte on the expiry cycle wins over the timeout.
            if (rx_done_tick) begin
               load_b     = 1'b1;
               cnt_next   = '0;
               state_next = WAIT_OP;
            end else if (cnt == CNT_MAX) begin
               expire     = 1'b1;
               cnt_next   = '0;
               state_next = WAIT_A;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         WAIT_OP: begin
            if (rx_done_tick) begin
               load_op    = 1'b1;
               cnt_next   = '0;
               state_next = CALC;
            end else if (cnt == CNT_MAX) begin
               expire     = 1'b1;
               cnt_next   = '0;
               state_next = WAIT_A;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         CALC: begin
            load_tx    = 1'b1;
            rx_over    = rx_done_tick;
            state_next = SEND;
         end
         SEND: begin
            rx_over    = rx_done_tick;
            state_next = WAIT_TX;
         end
         WAIT_TX: begin
            rx_over = rx_done_tick;
            if (tx_done_tick) state_next = WAIT_A;
         end
         default: state_next = WAIT_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= WAIT_A;
         cnt       <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         tx_data   <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         frame_err <= expire;
         overrun   <= rx_over;
         if (load_a)  alu_a   <= rx_data;
         if (load_b)  alu_b   <= rx_data;
         if (load_op) alu_op  <= rx_data[NB_OP-1:0];
         if (load_tx) tx_data <= alu_result;
      end
   end

   assign tx_start  = (state == SEND);
   assign fsm_state = state;

endmodule
